// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 scancode decoder: make/break/E0/E1 sequences, modifier tracking,
// typematic repeat filtering and a first-word-fall-through event FIFO.
module ps2_key_event_decoder #(
    parameter int FIFO_DEPTH       = 8,
    parameter int COUNT_W          = 8,
    parameter int TYPEMATIC_FILTER = 1
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [13:0]                   ev_data,
    output logic [3:0]                    mods,
    output logic [COUNT_W-1:0]            key_count,
    output logic [13:0]                   last_event,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          seq_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

    state_t        st, st_n;
    logic [2:0]    skip, skip_n;
    logic [5:0]    hk, hk_n;        // {ralt, lalt, rctrl, lctrl, rshift, lshift}
    logic          caps, caps_n;
    logic [8:0]    held;
    logic          held_vld;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [13:0]   mem [FIFO_DEPTH];

    logic        acc, emit, is_brk, is_ext, err, drop, push, pop, full;
    logic [7:0]  code;
    logic [8:0]  key;
    logic [3:0]  mods_n;
    logic [13:0] ev_word;

    assign full     = fifo_level == (AW+1)'(FIFO_DEPTH);
    assign in_ready = !full;
    assign ev_valid = fifo_level != '0;
    assign ev_data  = ev_valid ? mem[rd_ptr] : '0;
    assign acc      = in_valid && in_ready;
    assign pop      = ev_valid && ev_ready;
    assign mods     = {caps, hk[5] | hk[4], hk[3] | hk[2], hk[1] | hk[0]};

    always_comb begin
        st_n   = st;
        skip_n = skip;
        emit   = 1'b0;
        is_brk = 1'b0;
        is_ext = 1'b0;
        err    = 1'b0;
        code   = in_data;
        if (acc) begin
            case (st)
                S_IDLE: case (in_data)
                    8'hE0: st_n = S_EXT;
                    8'hF0: st_n = S_BRK;
                    8'hE1: begin st_n = S_PAUSE; skip_n = 3'd7; end
                    8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                    default: emit = 1'b1;
                endcase
                S_EXT: begin
                    st_n = S_IDLE;
                    case (in_data)
                        8'hF0:        st_n = S_EXT_BRK;
                        8'hE0, 8'hE1: err = 1'b1;
                        default: begin emit = 1'b1; is_ext = 1'b1; end
                    endcase
                end
                S_BRK, S_EXT_BRK: begin
                    st_n = S_IDLE;
                    if (in_data == 8'hE0 || in_data == 8'hF0 || in_data == 8'hE1)
                        err = 1'b1;
                    else begin
                        emit   = 1'b1;
                        is_brk = 1'b1;
                        is_ext = st == S_EXT_BRK;
                    end
                end
                S_PAUSE: begin
                    // the 7th trailing byte completes the pause sequence
                    if (skip == 3'd1) begin
                        st_n   = S_IDLE;
                        emit   = 1'b1;
                        is_ext = 1'b1;
                        code   = 8'hE1;
                    end
                    skip_n = skip - 3'd1;
                end
                default: st_n = S_IDLE;
            endcase
        end

        key  = {is_ext, code};
        drop = (TYPEMATIC_FILTER != 0) && emit && !is_brk && held_vld && held == key;
        push = emit && !drop;

        hk_n = hk;
        if (emit) begin
            case (key)
                9'h012: hk_n[0] = !is_brk;
                9'h059: hk_n[1] = !is_brk;
                9'h014: hk_n[2] = !is_brk;
                9'h114: hk_n[3] = !is_brk;
                9'h011: hk_n[4] = !is_brk;
                9'h111: hk_n[5] = !is_brk;
                default: ;
            endcase
        end
        caps_n  = caps ^ (push && !is_brk && key == 9'h058);
        mods_n  = {caps_n, hk_n[5] | hk_n[4], hk_n[3] | hk_n[2], hk_n[1] | hk_n[0]};
        ev_word = {is_ext, is_brk, mods_n, code};
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            st         <= S_IDLE;
            skip       <= '0;
            hk         <= '0;
            caps       <= 1'b0;
            held       <= '0;
            held_vld   <= 1'b0;
            key_count  <= '0;
            last_event <= '0;
            seq_err    <= 1'b0;
        end else begin
            st   <= st_n;
            skip <= skip_n;
            hk   <= hk_n;
            caps <= caps_n;
            if (err)
                seq_err <= 1'b1;
            if (push) begin
                last_event <= ev_word;
                if (!is_brk)
                    key_count <= key_count + 1'b1;
            end
            if (push && !is_brk) begin
                held     <= key;
                held_vld <= 1'b1;
            end else if (emit && is_brk && held_vld && held == key) begin
                held_vld <= 1'b0;
            end
        end
    end

    // push only happens when not full, so a simultaneous pop never overflows
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ev_word;
    end
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder; expected events go to a queue
// that an independent monitor pops as the DUT presents them.
module tb_ps2_key_event_decoder;
    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        ev_valid;
    logic        ev_ready = 1'b1;
    logic [13:0] ev_data;
    logic [3:0]  mods;
    logic [7:0]  key_count;
    logic [13:0] last_event;
    logic [3:0]  fifo_level;
    logic        seq_err;

    int total = 0;
    int bad   = 0;
    logic [13:0] exp_q[$];

    ps2_key_event_decoder #(.FIFO_DEPTH(8), .COUNT_W(8), .TYPEMATIC_FILTER(1)) dut (
        .clk(clk), .clrn(clrn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_data(ev_data), .mods(mods), .key_count(key_count),
        .last_event(last_event), .fifo_level(fifo_level), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ev_valid && ev_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event got=%h expected=none", ev_data);
            end else begin
                logic [13:0] e;
                e = exp_q.pop_front();
                if (ev_data !== e) begin
                    bad++;
                    $display("FAIL event got=%h expected=%h", ev_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // inputs change just after posedge; in_ready is sampled at the negedge before the edge
    task automatic send(input logic [7:0] b);
        bit ok = 0;
        @(posedge clk); #1;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout byte=%h", b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !ev_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL drain_timeout pending=%0d expected=0", exp_q.size());
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ev_valid"}, ev_valid, 0);
        chk({tag, "_ev_data"}, ev_data, 0);
        chk({tag, "_mods"}, mods, 0);
        chk({tag, "_key_count"}, key_count, 0);
        chk({tag, "_last_event"}, last_event, 0);
        chk({tag, "_fifo_level"}, fifo_level, 0);
        chk({tag, "_seq_err"}, seq_err, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    logic [7:0] fill [9] = '{8'h15, 8'h1A, 8'h1B, 8'h1D, 8'h21, 8'h22, 8'h23, 8'h24, 8'h2B};

    initial begin
        #12;
        chk_zero("reset");
        clrn = 1'b1;

        // plain make and break
        exp_q.push_back(14'h001C); exp_q.push_back(14'h101C);
        send(8'h1C); send(8'hF0); send(8'h1C);
        drain();
        chk("t1_key_count", key_count, 1);
        chk("t1_mods", mods, 0);

        // shift held, typematic repeats of 1C dropped
        exp_q.push_back(14'h0112); exp_q.push_back(14'h011C);
        exp_q.push_back(14'h111C); exp_q.push_back(14'h1012);
        send(8'h12); send(8'h1C); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        drain();
        chk("t2_key_count", key_count, 3);
        chk("t2_mods", mods, 0);

        // extended keys and left/right ctrl
        exp_q.push_back(14'h2075); exp_q.push_back(14'h3075);
        exp_q.push_back(14'h0214); exp_q.push_back(14'h2214); exp_q.push_back(14'h3214);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h14); send(8'hE0); send(8'h14); send(8'hE0); send(8'hF0); send(8'h14);
        drain();
        chk("t3_ctrl_still_held", mods, 4'b0010);
        exp_q.push_back(14'h1014);
        send(8'hF0); send(8'h14);
        drain();
        chk("t3_mods_clear", mods, 0);

        // caps lock toggles on each emitted make
        exp_q.push_back(14'h0858); exp_q.push_back(14'h1858);
        send(8'h58); send(8'hF0); send(8'h58);
        drain();
        chk("caps_on", mods, 4'b1000);
        exp_q.push_back(14'h0058); exp_q.push_back(14'h1058);
        send(8'h58); send(8'hF0); send(8'h58);
        drain();
        chk("caps_off", mods, 0);
        chk("caps_key_count", key_count, 8);

        // pause sequence: one event only
        exp_q.push_back(14'h20E1);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        drain();
        chk("pause_key_count", key_count, 9);
        chk("pause_seq_err", seq_err, 0);
        chk("pause_last_event", last_event, 14'h20E1);

        // illegal E0 E0, then FSM is back in IDLE
        send(8'hE0); send(8'hE0);
        @(negedge clk);
        chk("seq_err_set", seq_err, 1);
        exp_q.push_back(14'h001C); exp_q.push_back(14'h101C);
        send(8'h1C); send(8'hF0); send(8'h1C);
        drain();
        chk("after_err_key_count", key_count, 10);
        chk("seq_err_sticky", seq_err, 1);

        // FIFO full backpressure
        @(posedge clk); #1;
        ev_ready = 1'b0;
        for (int i = 0; i < 9; i++) exp_q.push_back({6'b0, fill[i]});
        for (int i = 0; i < 8; i++) send(fill[i]);
        @(posedge clk); #1;
        in_data  = fill[8];
        in_valid = 1'b1;
        @(negedge clk);
        chk("full_level", fifo_level, 8);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        ev_ready = 1'b1;
        @(negedge clk);
        chk("full_still_blocked", in_ready, 0);
        @(posedge clk); #1;
        ev_ready = 1'b0;
        @(negedge clk);
        chk("after_pop_in_ready", in_ready, 1);
        chk("after_pop_level", fifo_level, 7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("refill_level", fifo_level, 8);
        chk("refill_key_count", key_count, 19);
        chk("refill_last_event", last_event, 14'h002B);
        @(posedge clk); #1;
        ev_ready = 1'b1;
        drain();

        // asynchronous reset mid-sequence
        send(8'hE0); send(8'hF0);
        #3;
        clrn = 1'b0;
        #1;
        chk_zero("async_reset");
        @(posedge clk); #1;
        clrn = 1'b1;
        exp_q.push_back(14'h001C);
        send(8'h1C);
        drain();
        chk("post_reset_key_count", key_count, 1);
        chk("post_reset_seq_err", seq_err, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
